// File: rtl/params_pkg.sv
// Shared widths and types for the CPU-side memory path.
package params_pkg;

  localparam int unsigned ADDR_WIDTH          = 32;
  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned DEFAULT_ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single imem request/response port between instruction fetch and
// load/store, with data priority, a fetch starvation guard and a response timeout.
module mem_port_arbiter
  import params_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT        = DEFAULT_ARB_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] if_req_addr_i,
  output logic                  if_req_ready_o,
  output logic                  if_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] if_rsp_data_o,
  input  logic                  dm_rd_req_valid_i,
  input  logic                  dm_wr_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wr_data_i,
  input  access_size_t          dm_req_size_i,
  output logic                  dm_req_ready_o,
  output logic                  dm_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] dm_rsp_data_o,
  output logic                  mem_rd_req_valid_o,
  output logic                  mem_wr_req_valid_o,
  output logic                  mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0] mem_req_address_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output access_size_t          mem_req_access_size_o,
  input  logic                  mem_data_valid_i,
  input  logic                  mem_data_is_instr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  err_timeout_o,
  output logic                  err_tag_o
);

  localparam int unsigned BURST_W = $clog2(MAX_DATA_BURST + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  is_wr_q, is_wr_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mem_instr_q, mem_instr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  access_size_t          mem_size_q, mem_size_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_tag_q, err_tag_d;

  logic                  data_req;
  logic                  fetch_wins;
  logic                  grant_fetch;
  logic                  grant_data;
  logic                  timed_out;
  logic                  rsp_fire;
  logic                  tag_bad;
  logic [DATA_WIDTH-1:0] rsp_data;

  // A waiting fetch wins when no data request is pending or its burst budget is spent.
  function automatic logic fetch_priority(input logic if_valid, input logic dm_valid,
                                          input logic burst_full);
    return if_valid && (!dm_valid || burst_full);
  endfunction

  always_comb begin
    data_req    = dm_rd_req_valid_i || dm_wr_req_valid_i;
    fetch_wins  = fetch_priority(if_req_valid_i, data_req,
                                 burst_q == BURST_W'(MAX_DATA_BURST));
    grant_fetch = (state_q == IDLE) && fetch_wins;
    grant_data  = (state_q == IDLE) && data_req && !fetch_wins;
    timed_out   = (state_q == WAIT) && !mem_data_valid_i && (tmo_q == TMO_W'(TIMEOUT - 1));
    rsp_fire    = (state_q == WAIT) && (mem_data_valid_i || timed_out);
    tag_bad     = (state_q == WAIT) && mem_data_valid_i &&
                  (mem_data_is_instr_i != (owner_q == OWNER_FETCH));
    // Store acks and timeouts return zero data.
    rsp_data    = ((state_q == WAIT) && mem_data_valid_i && !is_wr_q) ? mem_data_i : '0;
  end

  assign if_req_ready_o = grant_fetch;
  assign dm_req_ready_o = grant_data;
  assign if_rsp_valid_o = rsp_fire && (owner_q == OWNER_FETCH);
  assign dm_rsp_valid_o = rsp_fire && (owner_q == OWNER_DATA);
  assign if_rsp_data_o  = if_rsp_valid_o ? rsp_data : '0;
  assign dm_rsp_data_o  = dm_rsp_valid_o ? rsp_data : '0;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    is_wr_d       = is_wr_q;
    burst_d       = burst_q;
    tmo_d         = tmo_q;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_instr_d   = mem_instr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_size_d    = mem_size_q;
    err_timeout_d = err_timeout_q || timed_out;
    err_tag_d     = err_tag_q || tag_bad;

    unique case (state_q)
      IDLE: begin
        if (!if_req_valid_i || grant_fetch) begin
          burst_d = '0;
        end else if (grant_data && (burst_q != BURST_W'(MAX_DATA_BURST))) begin
          burst_d = burst_q + BURST_W'(1);
        end
        if (grant_fetch) begin
          state_d     = ISSUE;
          owner_d     = OWNER_FETCH;
          is_wr_d     = 1'b0;
          mem_rd_d    = 1'b1;
          mem_instr_d = 1'b1;
          mem_addr_d  = if_req_addr_i;
          mem_wdata_d = '0;
          mem_size_d  = WORD;
        end else if (grant_data) begin
          // Simultaneous rd and wr is treated as a write.
          state_d     = ISSUE;
          owner_d     = OWNER_DATA;
          is_wr_d     = dm_wr_req_valid_i;
          mem_rd_d    = !dm_wr_req_valid_i;
          mem_wr_d    = dm_wr_req_valid_i;
          mem_instr_d = 1'b0;
          mem_addr_d  = dm_req_addr_i;
          mem_wdata_d = dm_wr_data_i;
          mem_size_d  = dm_req_size_i;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        if (rsp_fire) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_DATA;
      is_wr_q       <= 1'b0;
      burst_q       <= '0;
      tmo_q         <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_instr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_size_q    <= BYTE;
      err_timeout_q <= 1'b0;
      err_tag_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      is_wr_q       <= is_wr_d;
      burst_q       <= burst_d;
      tmo_q         <= tmo_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_instr_q   <= mem_instr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_size_q    <= mem_size_d;
      err_timeout_q <= err_timeout_d;
      err_tag_q     <= err_tag_d;
    end
  end

  assign mem_rd_req_valid_o    = mem_rd_q;
  assign mem_wr_req_valid_o    = mem_wr_q;
  assign mem_req_is_instr_o    = mem_instr_q;
  assign mem_req_address_o     = mem_addr_q;
  assign mem_wr_data_o         = mem_wdata_q;
  assign mem_req_access_size_o = mem_size_q;
  assign err_timeout_o         = err_timeout_q;
  assign err_tag_o             = err_tag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a memory model and a response monitor.
module tb_mem_port_arbiter;
  import params_pkg::*;

  localparam int unsigned AW = params_pkg::ADDR_WIDTH;
  localparam int unsigned DW = params_pkg::DATA_WIDTH;

  logic clk_i, rst_i;
  logic if_req_valid_i, if_req_ready_o, if_rsp_valid_o;
  logic [AW-1:0] if_req_addr_i;
  logic [DW-1:0] if_rsp_data_o;
  logic dm_rd_req_valid_i, dm_wr_req_valid_i, dm_req_ready_o, dm_rsp_valid_o;
  logic [AW-1:0] dm_req_addr_i;
  logic [DW-1:0] dm_wr_data_i, dm_rsp_data_o;
  access_size_t dm_req_size_i, mem_req_access_size_o;
  logic mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o;
  logic [AW-1:0] mem_req_address_o;
  logic [DW-1:0] mem_wr_data_o, mem_data_i;
  logic mem_data_valid_i, mem_data_is_instr_i, err_timeout_o, err_tag_o;

  mem_port_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i),
    .if_req_ready_o(if_req_ready_o), .if_rsp_valid_o(if_rsp_valid_o),
    .if_rsp_data_o(if_rsp_data_o),
    .dm_rd_req_valid_i(dm_rd_req_valid_i), .dm_wr_req_valid_i(dm_wr_req_valid_i),
    .dm_req_addr_i(dm_req_addr_i), .dm_wr_data_i(dm_wr_data_i),
    .dm_req_size_i(dm_req_size_i), .dm_req_ready_o(dm_req_ready_o),
    .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rsp_data_o(dm_rsp_data_o),
    .mem_rd_req_valid_o(mem_rd_req_valid_o), .mem_wr_req_valid_o(mem_wr_req_valid_o),
    .mem_req_is_instr_o(mem_req_is_instr_o), .mem_req_address_o(mem_req_address_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_req_access_size_o(mem_req_access_size_o),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
    .mem_data_i(mem_data_i),
    .err_timeout_o(err_timeout_o), .err_tag_o(err_tag_o)
  );

  typedef struct {
    bit           is_fetch;
    bit           wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    access_size_t size;
  } req_t;

  typedef struct {
    bit            rd;
    bit            wr;
    bit            instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    access_size_t  size;
  } exp_req_t;

  typedef struct {
    bit            is_fetch;
    bit            tmo;
    logic [DW-1:0] data;
  } exp_rsp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int issue_cyc = 0;
  int rsp_cnt  = 0;
  int fwait    = 0;
  int grant_n  = 0;
  logic [15:0] grant_seq = '0;

  req_t     fq[$];
  req_t     dq[$];
  exp_req_t exp_req_q[$];
  exp_rsp_t exp_rsp_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];

  bit mem_mute = 0;
  bit mem_tag_flip = 0;
  bit inject_rsp = 0;
  int mem_lat = 2;
  bit pend = 0;
  int pend_cnt = 0;
  bit pend_instr = 0;
  logic [DW-1:0] pend_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] default_word(input logic [AW-1:0] a);
    return DW'(a) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  function automatic req_t mk(input bit f, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input access_size_t s);
    req_t r;
    r.is_fetch = f; r.wr = w; r.addr = a; r.wdata = d; r.size = s;
    return r;
  endfunction

  // Record a grant and the request/response it must produce.
  task automatic accept(input req_t r);
    exp_req_t m;
    exp_rsp_t e;
    grant_seq = {grant_seq[14:0], r.is_fetch};
    grant_n++;
    m.rd = !r.wr; m.wr = r.wr; m.instr = r.is_fetch; m.addr = r.addr;
    m.wdata = r.wdata; m.size = r.is_fetch ? WORD : r.size;
    exp_req_q.push_back(m);
    e.is_fetch = r.is_fetch;
    e.tmo = mem_mute;
    e.data = (r.wr || mem_mute) ? '0 : ref_rd(r.addr);
    if (r.wr) ref_mem[r.addr] = r.wdata;
    exp_rsp_q.push_back(e);
  endtask

  task automatic run_fetch();
    while (fq.size() > 0) begin
      req_t r;
      bit done;
      int w;
      r = fq.pop_front();
      done = 0; w = 0;
      if_req_valid_i = 1'b1; if_req_addr_i = r.addr;
      while (!done && w < 300) begin
        @(negedge clk_i);
        if (if_req_ready_o) begin done = 1; accept(r); end
        @(posedge clk_i); #1;
        if (!done) w++;
      end
      fwait = w;
      if (!done) check_eq("if_grant_wait", 64'(done), 1);
      if_req_valid_i = 1'b0;
    end
  endtask

  task automatic run_data();
    while (dq.size() > 0) begin
      req_t r;
      bit done;
      int w;
      r = dq.pop_front();
      done = 0; w = 0;
      dm_rd_req_valid_i = !r.wr; dm_wr_req_valid_i = r.wr;
      dm_req_addr_i = r.addr; dm_wr_data_i = r.wdata; dm_req_size_i = r.size;
      while (!done && w < 300) begin
        @(negedge clk_i);
        if (dm_req_ready_o) begin done = 1; accept(r); end
        @(posedge clk_i); #1;
        if (!done) w++;
      end
      if (!done) check_eq("dm_grant_wait", 64'(done), 1);
      dm_rd_req_valid_i = 1'b0; dm_wr_req_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_rsp_q.size() != 0 && i < 300) begin
      @(negedge clk_i);
      i++;
    end
    check_eq("drain_done", 64'(exp_rsp_q.size()), 0);
    @(posedge clk_i); #1;
  endtask

  function automatic logic outs_any();
    return |{if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, dm_req_ready_o, dm_rsp_valid_o,
             dm_rsp_data_o, mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
             mem_req_address_o, mem_wr_data_o, mem_req_access_size_o, err_timeout_o, err_tag_o};
  endfunction

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: checks each issued request and answers after mem_lat cycles.
  initial begin
    mem_data_valid_i = 1'b0; mem_data_is_instr_i = 1'b0; mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_data_valid_i = 1'b0; mem_data_is_instr_i = 1'b0; mem_data_i = '0;
      if (inject_rsp) begin
        mem_data_valid_i = 1'b1; mem_data_i = 32'h1234_5678; inject_rsp = 0;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_data_valid_i = 1'b1;
          mem_data_is_instr_i = pend_instr ^ mem_tag_flip;
          mem_data_i = pend_data;
          pend = 0;
        end
      end
      if (mem_rd_req_valid_o || mem_wr_req_valid_o) begin
        issue_cyc = cyc;
        if (exp_req_q.size() == 0) begin
          check_eq("mem_req_unexpected", 64'(exp_req_q.size()), 1);
        end else begin
          exp_req_t m;
          m = exp_req_q.pop_front();
          check_eq("mem_rd", 64'(mem_rd_req_valid_o), 64'(m.rd));
          check_eq("mem_wr", 64'(mem_wr_req_valid_o), 64'(m.wr));
          check_eq("mem_instr", 64'(mem_req_is_instr_o), 64'(m.instr));
          check_eq("mem_addr", 64'(mem_req_address_o), 64'(m.addr));
          check_eq("mem_size", 64'(mem_req_access_size_o), 64'(m.size));
          if (m.wr) check_eq("mem_wdata", 64'(mem_wr_data_o), 64'(m.wdata));
        end
        if (mem_wr_req_valid_o) begin
          mem_arr[mem_req_address_o] = mem_wr_data_o;
          pend_data = 32'hFFFF_FFFF;
        end else begin
          pend_data = mem_arr.exists(mem_req_address_o) ? mem_arr[mem_req_address_o]
                                                        : default_word(mem_req_address_o);
        end
        if (!mem_mute) begin
          pend = 1; pend_cnt = mem_lat; pend_instr = mem_req_is_instr_o;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response.
  always @(negedge clk_i) begin
    if (!rst_i && (if_rsp_valid_o || dm_rsp_valid_o)) begin
      rsp_cnt++;
      check_eq("rsp_onehot", 64'(if_rsp_valid_o && dm_rsp_valid_o), 0);
      if (exp_rsp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(exp_rsp_q.size()), 1);
      end else begin
        exp_rsp_t e;
        e = exp_rsp_q.pop_front();
        check_eq("rsp_owner_fetch", 64'(if_rsp_valid_o), 64'(e.is_fetch));
        check_eq("rsp_data", 64'(e.is_fetch ? if_rsp_data_o : dm_rsp_data_o), 64'(e.data));
        if (e.tmo) check_eq("timeout_cycle", 64'(cyc - issue_cyc), 64);
      end
    end
  end

  initial begin
    int n0;
    rst_i = 1'b1;
    if_req_valid_i = 1'b0; if_req_addr_i = '0;
    dm_rd_req_valid_i = 1'b0; dm_wr_req_valid_i = 1'b0;
    dm_req_addr_i = '0; dm_wr_data_i = '0; dm_req_size_i = WORD;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("reset_outs_zero", 64'(outs_any()), 0);
    @(posedge clk_i); #1;

    // fetch only
    mem_arr[32'h4] = 32'h446F1; ref_mem[32'h4] = 32'h446F1;
    fq.push_back(mk(1, 0, 32'h4, '0, WORD));
    run_fetch();
    check_eq("fetch_ready_first_cycle", 64'(fwait), 0);
    drain();

    // simultaneous fetch and load: load first
    grant_seq = '0; grant_n = 0;
    fq.push_back(mk(1, 0, 32'h8, '0, WORD));
    dq.push_back(mk(0, 0, 32'h100, '0, WORD));
    fork run_fetch(); run_data(); join
    drain();
    check_eq("grant_order_pair", 64'(grant_seq), 64'b01);
    check_eq("grant_count_pair", 64'(grant_n), 2);

    // starvation guard: fetch takes the fifth slot
    grant_seq = '0; grant_n = 0;
    fq.push_back(mk(1, 0, 32'hC, '0, WORD));
    for (int i = 0; i < 5; i++) dq.push_back(mk(0, 0, AW'(32'h100 + 4 * i), '0, WORD));
    fork run_fetch(); run_data(); join
    drain();
    check_eq("grant_order_burst", 64'(grant_seq), 64'b000010);
    check_eq("grant_count_burst", 64'(grant_n), 6);

    // store then load back, plus a byte load
    dq.push_back(mk(0, 1, 32'h40, 32'hDEAD_BEEF, WORD));
    dq.push_back(mk(0, 0, 32'h40, '0, WORD));
    dq.push_back(mk(0, 0, 32'h41, '0, BYTE));
    run_data();
    drain();
    check_eq("err_tag_clean", 64'(err_tag_o), 0);
    check_eq("err_timeout_clean", 64'(err_timeout_o), 0);

    // timeout, then a late response
    mem_mute = 1;
    dq.push_back(mk(0, 0, 32'h200, '0, WORD));
    run_data();
    drain();
    mem_mute = 0;
    check_eq("err_timeout_set", 64'(err_timeout_o), 1);
    n0 = rsp_cnt;
    @(negedge clk_i); inject_rsp = 1;
    repeat (3) @(negedge clk_i);
    check_eq("late_rsp_ignored", 64'(rsp_cnt), 64'(n0));
    @(posedge clk_i); #1;

    // wrong tag on a load still routes to data side
    mem_tag_flip = 1;
    dq.push_back(mk(0, 0, 32'h104, '0, WORD));
    run_data();
    drain();
    mem_tag_flip = 0;
    check_eq("err_tag_set", 64'(err_tag_o), 1);

    // reset while waiting
    mem_mute = 1;
    fq.push_back(mk(1, 0, 32'h4, '0, WORD));
    run_fetch();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    exp_rsp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    mem_mute = 0;
    @(negedge clk_i);
    check_eq("outs_zero_after_reset", 64'(outs_any()), 0);
    n0 = rsp_cnt;
    inject_rsp = 1;
    repeat (3) @(negedge clk_i);
    check_eq("post_reset_rsp_ignored", 64'(rsp_cnt), 64'(n0));
    @(posedge clk_i); #1;
    fq.push_back(mk(1, 0, 32'h4, '0, WORD));
    run_fetch();
    drain();
    check_eq("post_reset_served", 64'(rsp_cnt), 64'(n0 + 1));
    check_eq("err_tag_after_reset", 64'(err_tag_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
